// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data requesters, data first.
// Optional watchdog enabled by defining MEMARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_valid,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          err
);

    typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StResp} state_e;

    state_e        r_state, w_state_d;
    logic          r_m_valid, w_m_valid_d;
    logic          r_m_we, w_m_we_d;
    logic [AW-1:0] r_m_addr, w_m_addr_d;
    logic [DW-1:0] r_m_wdata, w_m_wdata_d;
    logic [DW-1:0] r_i_rdata, w_i_rdata_d;
    logic [DW-1:0] r_d_rdata, w_d_rdata_d;
    logic          r_i_ack, w_i_ack_d;
    logic          r_d_ack, w_d_ack_d;
    logic          r_err, w_err_d;
    logic          w_busy;
    logic          w_timeout;

    assign w_busy = (r_state == StIBusy) || (r_state == StDBusy);

`ifdef MEMARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WdLast = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_wd_cnt;

    // Fires on the stalled busy cycle that would bring the count up to TIMEOUT.
    assign w_timeout = w_busy && !m_ready && (r_wd_cnt == WdLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wd_cnt <= '0;
        end else if (r_state == StIdle) begin
            r_wd_cnt <= '0;
        end else if (w_busy && !m_ready) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_m_valid_d = r_m_valid;
        w_m_we_d    = r_m_we;
        w_m_addr_d  = r_m_addr;
        w_m_wdata_d = r_m_wdata;
        w_i_rdata_d = r_i_rdata;
        w_d_rdata_d = r_d_rdata;
        w_i_ack_d   = 1'b0;
        w_d_ack_d   = 1'b0;
        w_err_d     = r_err;
        unique case (r_state)
            StIdle: begin
                if (d_req) begin
                    w_state_d   = StDBusy;
                    w_m_valid_d = 1'b1;
                    w_m_we_d    = d_we;
                    w_m_addr_d  = d_addr;
                    w_m_wdata_d = d_wdata;
                end else if (i_req) begin
                    w_state_d   = StIBusy;
                    w_m_valid_d = 1'b1;
                    w_m_we_d    = 1'b0;
                    w_m_addr_d  = i_addr;
                    w_m_wdata_d = '0;
                end
            end
            StIBusy, StDBusy: begin
                if (m_ready || w_timeout) begin
                    w_state_d   = StResp;
                    w_m_valid_d = 1'b0;
                    w_err_d     = r_err | !m_ready;
                    if (r_state == StIBusy) begin
                        w_i_ack_d   = 1'b1;
                        w_i_rdata_d = m_ready ? m_rdata : '0;
                    end else begin
                        w_d_ack_d = 1'b1;
                        if (!r_m_we) begin
                            w_d_rdata_d = m_ready ? m_rdata : '0;
                        end
                    end
                end
            end
            // No arbitration here so a still-high req from the acked owner is not re-granted.
            StResp: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_m_valid <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_m_valid <= w_m_valid_d;
            r_m_we    <= w_m_we_d;
            r_m_addr  <= w_m_addr_d;
            r_m_wdata <= w_m_wdata_d;
            r_i_rdata <= w_i_rdata_d;
            r_d_rdata <= w_d_rdata_d;
            r_i_ack   <= w_i_ack_d;
            r_d_ack   <= w_d_ack_d;
            r_err     <= w_err_d;
        end
    end

    assign m_valid = r_m_valid;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign err     = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; timeout scenario runs when
// MEMARB_TIMEOUT_EN is defined (DUT built with TIMEOUT=8).
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("FAIL rst_m_we got %b want 0", m_we); end
        n_cmp++; if (m_addr !== 32'h0) begin n_bad++; $display("FAIL rst_m_addr got %h want 0", m_addr); end
        n_cmp++; if (m_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_m_wdata got %h want 0", m_wdata); end
        n_cmp++; if ({i_ack, d_ack, err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {i_ack, d_ack, err}); end
        n_cmp++; if ({i_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", {i_rdata, d_rdata}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_access();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; m_ready = 1'b0;
        tick();
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL mid_busy_valid got %b want 1", m_valid); end
        n_cmp++; if (m_addr !== 32'h40) begin n_bad++; $display("FAIL mid_busy_addr got %h want 00000040", m_addr); end
        tick();
        reset = 1'b0; d_req = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", m_valid); end
        n_cmp++; if (m_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_addr got %h want 0", m_addr); end
        n_cmp++; if ({i_ack, d_ack} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_ack got %b want 00", {i_ack, d_ack}); end
        tick();
        tick();
        n_cmp++; if ({m_valid, d_ack} !== 2'b00) begin n_bad++; $display("FAIL mid_idle got %b want 00", {m_valid, d_ack}); end
    endtask

    task automatic test_fetch_zero_wait();
        i_req = 1'b1; i_addr = 32'h0000_0004; m_ready = 1'b1; m_rdata = 32'h2008_0005;
        tick();
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL fz_valid got %b want 1", m_valid); end
        n_cmp++; if (m_addr !== 32'h4) begin n_bad++; $display("FAIL fz_addr got %h want 00000004", m_addr); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("FAIL fz_we got %b want 0", m_we); end
        n_cmp++; if (i_ack !== 1'b0) begin n_bad++; $display("FAIL fz_early_ack got %b want 0", i_ack); end
        tick();
        n_cmp++; if ({i_ack, d_ack, m_valid} !== 3'b100) begin n_bad++; $display("FAIL fz_resp got %b want 100", {i_ack, d_ack, m_valid}); end
        n_cmp++; if (i_rdata !== 32'h2008_0005) begin n_bad++; $display("FAIL fz_rdata got %h want 20080005", i_rdata); end
        i_req = 1'b0;
        tick();
        n_cmp++; if ({i_ack, m_valid} !== 2'b00) begin n_bad++; $display("FAIL fz_idle got %b want 00", {i_ack, m_valid}); end
        n_cmp++; if (i_rdata !== 32'h2008_0005) begin n_bad++; $display("FAIL fz_hold got %h want 20080005", i_rdata); end
    endtask

    task automatic test_wait_states();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; m_ready = 1'b0; m_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if ({m_valid, m_addr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL ws_busy%0d got %b/%h want 1/00000100", k, m_valid, m_addr); end
            n_cmp++; if (d_ack !== 1'b0) begin n_bad++; $display("FAIL ws_noack%0d got %b want 0", k, d_ack); end
            if (k == 4) begin m_ready = 1'b1; m_rdata = 32'h1234_5678; end
        end
        tick();
        n_cmp++; if ({d_ack, m_valid} !== 2'b10) begin n_bad++; $display("FAIL ws_resp got %b want 10", {d_ack, m_valid}); end
        n_cmp++; if (d_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL ws_rdata got %h want 12345678", d_rdata); end
        d_req = 1'b0; m_ready = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        m_ready = 1'b1; m_rdata = 32'hAAAA_5555;
        tick();
        n_cmp++; if ({m_valid, m_we} !== 2'b11) begin n_bad++; $display("FAIL sim_store got %b want 11", {m_valid, m_we}); end
        n_cmp++; if ({m_addr, m_wdata} !== {32'h80, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL sim_store_bus got %h/%h want 00000080/deadbeef", m_addr, m_wdata); end
        tick();
        n_cmp++; if ({d_ack, i_ack} !== 2'b10) begin n_bad++; $display("FAIL sim_dack got %b want 10", {d_ack, i_ack}); end
        n_cmp++; if (d_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL sim_store_rdata got %h want 12345678", d_rdata); end
        d_req = 1'b0;
        tick();
        n_cmp++; if ({d_ack, i_ack, m_valid} !== 3'b000) begin n_bad++; $display("FAIL sim_idle got %b want 000", {d_ack, i_ack, m_valid}); end
        tick();
        n_cmp++; if ({m_valid, m_we, m_addr, m_wdata} !== {2'b10, 32'h8, 32'h0}) begin n_bad++; $display("FAIL sim_fetch_bus got %b%b/%h/%h want 10/00000008/0", m_valid, m_we, m_addr, m_wdata); end
        tick();
        n_cmp++; if ({i_ack, d_ack} !== 2'b10) begin n_bad++; $display("FAIL sim_iack got %b want 10", {i_ack, d_ack}); end
        n_cmp++; if (i_rdata !== 32'hAAAA_5555) begin n_bad++; $display("FAIL sim_irdata got %h want aaaa5555", i_rdata); end
        n_cmp++; if (d_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL sim_drdata_kept got %h want 12345678", d_rdata); end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_no_double_grant();
        i_req = 1'b1; i_addr = 32'hC; m_ready = 1'b1; m_rdata = 32'h1111_1111;
        tick();
        tick();
        n_cmp++; if ({i_ack, i_rdata} !== {1'b1, 32'h1111_1111}) begin n_bad++; $display("FAIL ndg_first got %b/%h want 1/11111111", i_ack, i_rdata); end
        tick();
        n_cmp++; if ({i_ack, m_valid} !== 2'b00) begin n_bad++; $display("FAIL ndg_gap got %b want 00", {i_ack, m_valid}); end
        tick();
        n_cmp++; if ({i_ack, m_valid} !== 2'b01) begin n_bad++; $display("FAIL ndg_regrant got %b want 01", {i_ack, m_valid}); end
        m_rdata = 32'h2222_2222;
        tick();
        n_cmp++; if ({i_ack, i_rdata} !== {1'b1, 32'h2222_2222}) begin n_bad++; $display("FAIL ndg_second got %b/%h want 1/22222222", i_ack, i_rdata); end
        i_req = 1'b0;
        tick();
        n_cmp++; if ({i_ack, m_valid} !== 2'b00) begin n_bad++; $display("FAIL ndg_end got %b want 00", {i_ack, m_valid}); end
    endtask

    task automatic test_err_state();
`ifdef MEMARB_TIMEOUT_EN
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; m_ready = 1'b0; m_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++; if ({m_valid, d_ack, err} !== 3'b100) begin n_bad++; $display("FAIL to_busy%0d got %b want 100", k, {m_valid, d_ack, err}); end
        end
        tick();
        n_cmp++; if ({d_ack, err, m_valid} !== 3'b110) begin n_bad++; $display("FAIL to_resp got %b want 110", {d_ack, err, m_valid}); end
        n_cmp++; if (d_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata got %h want 0", d_rdata); end
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10; m_ready = 1'b1; m_rdata = 32'h5;
        tick();
        tick();
        tick();
        n_cmp++; if ({i_ack, i_rdata, err} !== {1'b1, 32'h5, 1'b1}) begin n_bad++; $display("FAIL to_sticky got %b/%h/%b want 1/00000005/1", i_ack, i_rdata, err); end
        i_req = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_rst_err got %b want 0", err); end
`else
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_tied got %b want 0", err); end
`endif
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0;
        test_reset();
        test_reset_mid_access();
        test_fetch_zero_wait();
        test_wait_states();
        test_simultaneous();
        test_no_double_grant();
        test_err_state();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-ported, variable-latency memory between the pipeline's fetch stage (instruction requester) and memory stage (data requester). It arbitrates with fixed data-over-fetch priority and drives a registered request to the memory. It waits for the memory's ready, then returns read data with a one-cycle acknowledge. While a requester's `req` is high and its `ack` is low, the hazard logic uses that condition as the stall for the corresponding stage.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, watchdog limit in cycles (used only with `MEMARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  rising-edge clock, the only clock
- `reset`  in  1  synchronous, active-low reset; sampled on `clk`, takes effect when 0
- `i_req`  in  1  fetch request, held until `i_ack`
- `i_addr`  in  AW  fetch address, stable while `i_req`
- `i_rdata`  out  DW  fetched word, valid in the `i_ack` cycle and held afterwards
- `i_ack`  out  1  one-cycle fetch completion pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data, valid in the `d_ack` cycle and held afterwards
- `d_ack`  out  1  one-cycle data completion pulse
- `m_valid`  out  1  memory request active
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, valid when `m_ready`
- `m_ready`  in  1  memory completes the current access this cycle
- `err`  out  1  sticky timeout flag

## Operation
- States: IDLE, IBUSY, DBUSY, RESP.
- IDLE:
  - If `d_req`, latch `d_we`/`d_addr`/`d_wdata` into the `m_*` registers and go to DBUSY.
  - Else if `i_req`, latch `i_addr` with `m_we`=0 and `m_wdata`=0, and go to IBUSY.
  - Else stay in IDLE.
  - Data always wins a simultaneous request.
- IBUSY/DBUSY:
  - `m_valid`=1 and all `m_*` outputs are stable.
  - On `m_ready`=1: capture `m_rdata` into `i_rdata` (fetch) or `d_rdata` (load only), then go to RESP.
  - A store never updates `d_rdata`.
  - `m_rdata` is ignored when `m_ready`=0.
- RESP:
  - `m_valid`=0.
  - `i_ack` or `d_ack`=1 for exactly this cycle, for the owner of the completed access.
  - Next state is IDLE unconditionally.
  - Requests are not arbitrated in RESP, so the just-acked requester's still-high `req` is never re-granted.
- `i_ack` and `d_ack` are never high together. At most one memory access is outstanding.
- Reset (reset=0, any state, including mid-access):
  - State goes to IDLE; the memory access is abandoned.
  - `m_valid`, `m_we`, `i_ack`, `d_ack`, `err` = 0.
  - `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0.
  - Watchdog counter = 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Zero-wait access (request seen in IDLE at cycle 0, `m_ready` high in the first busy cycle):
  - Cycle 1: busy state, `m_valid`=1.
  - Cycle 2: RESP, `ack`=1.
  - Cycle 3: IDLE.
  - Three cycles per access.
- Each cycle that `m_ready` is low in the busy state adds one cycle.
- Back-to-back requests: the next request is sampled in the IDLE cycle following RESP.
- A `req` that deasserts before its `ack` is a protocol violation. The behaviour is undefined and the bench does not exercise it.

## Configuration
- `MEMARB_TIMEOUT_EN` defined:
  - An 8-bit counter (`$clog2(TIMEOUT+1)` bits) clears on entering IBUSY/DBUSY and increments each busy cycle with `m_ready`=0.
  - When it reaches `TIMEOUT`, the block goes to RESP. It acks the owner with rdata forced to 0 (loads and fetches) and sets `err`=1.
  - `err` is sticky until reset.
  - `m_ready` arriving in the same cycle as the limit takes precedence: normal completion, no error.
- Undefined: the block waits in the busy state indefinitely, `err` is tied to 0, and the counter does not exist.

## Test plan
- Reset mid-access:
  - Stimulus: `d_req` load of 0x40, `m_ready` held 0, then reset=0 for one cycle in DBUSY.
  - Required response: next cycle `m_valid`=0, no ack, state IDLE, all outputs 0.
- Single fetch, zero wait:
  - Stimulus: `i_req`, `i_addr`=0x0000_0004, `m_ready`=1, `m_rdata`=0x2008_0005 in the first busy cycle.
  - Required response: `i_ack` exactly 2 cycles after request sampling, `i_rdata`=0x2008_0005, `m_we`=0.
- Simultaneous requests:
  - Stimulus: `i_req` (0x8) and `d_req` store (addr 0x80, data 0xDEAD_BEEF) in the same cycle.
  - Required response: store issued first with `m_we`=1, `d_ack` first. The fetch issues in the IDLE after RESP, and `i_ack` arrives 3 cycles after `d_ack`. `d_rdata` is unchanged.
- Wait states:
  - Stimulus: load of 0x100, `m_ready` low for 4 cycles then high with 0x1234_5678.
  - Required response: `m_valid` high 5 cycles with stable addr, then `d_ack` with `d_rdata`=0x1234_5678.
- No double grant:
  - Stimulus: `i_req` held high across its own ack.
  - Required response: exactly one `i_ack` per access; a second access starts only from the IDLE after RESP.
- Timeout (`MEMARB_TIMEOUT_EN`, `TIMEOUT`=8):
  - Stimulus: `m_ready` stuck at 0.
  - Required response: `d_ack` after 8 busy cycles, `d_rdata`=0, `err`=1 and it stays 1 through further accesses until reset.
